mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Single-entry memory execution unit. Consumes the uop issued by the memory
//  issue queue after PRF read, together with its operand values. Computes the
//  effective address, runs one valid/ready request to the data-memory port,
//  aligns and sign-extends load data, and presents the finished uop for
//  writeback. ex_busy back-pressures the issue queue while an access is in flight.
// PARAMETERS
//  XLEN        32  data and address width
//  STRB_WIDTH  4   byte strobes per word (XLEN/8)
// PORTS
//  clock       in   1                 clock
//  reset       in   1                 reset, synchronous, active-high
//  clear_en    in   1                 pipeline flush (mispredict/exception)
//  uop_in      in   micro_op_t        issued mem uop; valid, mem_type, mem_size, mem_unsigned, imm
//  rs1_data    in   XLEN              base-address operand
//  rs2_data    in   XLEN              store-data operand
//  ex_busy     out  1                 unit cannot accept a uop this cycle
//  req_valid   out  1                 dmem request valid
//  req_ready   in   1                 dmem accepts request
//  req_we      out  1                 1 = store, 0 = load
//  req_addr    out  XLEN              word-aligned address ({ea[XLEN-1:2],2'b00})
//  req_wstrb   out  STRB_WIDTH        byte enables for stores; 0 for loads
//  req_wdata   out  XLEN              store data, shifted to byte lane
//  resp_valid  in   1                 load response valid (single cycle)
//  resp_rdata  in   XLEN              load response word
//  wb_valid    out  1                 uop_out/rd_data valid, single-cycle pulse
//  uop_out     out  micro_op_t        completed uop
//  rd_data     out  XLEN              load result; 0 for stores
//  misaligned  out  1                 with wb_valid: address misaligned, no access made
// BEHAVIOUR
//  States: IDLE, REQ, WAIT, DRAIN, WB. Reset -> IDLE; all outputs 0.
//  ex_busy = (state != IDLE). Registered; the issue queue samples it before issuing.
//  IDLE: on uop_in.valid & ~clear_en, latch the uop and compute
//    ea = rs1_data + sext(imm), taken mod 2^XLEN with wrap and no trap.
//    Misaligned (H: ea[0]!=0; W: ea[1:0]!=0) -> WB with misaligned=1 and no request.
//    Otherwise -> REQ.
//  REQ: req_valid=1. Address, we, strb and data are held stable until req_ready.
//    On req_valid & req_ready: store -> WB; load -> WAIT.
//  Store strobes: B = 4'b0001<<ea[1:0]; H = 4'b0011<<ea[1:0]; W = 4'b1111.
//    wdata = rs2_data << (8*ea[1:0]).
//  WAIT: on resp_valid, shift = resp_rdata >> (8*ea[1:0]). B/H are sign- or
//    zero-extended per mem_unsigned; W is passed through. Latch rd_data -> WB.
//  WB: wb_valid=1 for exactly one cycle -> IDLE. Accepting a new uop in the
//    same cycle is not allowed (ex_busy is still 1). Minimum latencies, issue
//    to wb_valid: store 2 cycles, load 3 cycles.
//  Response arriving in the same cycle as the request handshake is illegal
//    from dmem. This unit ignores it.
//  clear_en:
//    IDLE / REQ before handshake / WB -> IDLE, and the request is dropped.
//    WAIT -> DRAIN.
//    A REQ handshake in the same cycle as clear_en: store is committed and no
//    writeback; load -> DRAIN.
//    uop_in is ignored while clear_en=1.
//  DRAIN: ex_busy=1, wb_valid=0. On resp_valid the data is discarded -> IDLE.
//    Further clear_en has no extra effect.
//  Reset mid-access: -> IDLE immediately. dmem is reset alongside.
//  wb_valid and req_valid are never asserted while reset=1.
// TESTING
//  T1 LW rs1=0x1000 imm=4, req_ready=1, resp 0xDEADBEEF next cycle ->
//     req_addr=0x1004, strb=0, wb_valid at cycle 3, rd_data=0xDEADBEEF.
//  T2 SB rs1=0x2003 imm=0 rs2=0xAB, req_ready low 3 cycles ->
//     req_valid held 4 cycles, strb=4'b1000, wdata=0xAB000000, ex_busy=1 throughout.
//  T3 LB/LBU at ea[1:0]=2, resp 0x0080_0000 -> LB rd=0xFFFFFF80, LBU rd=0x00000080;
//     LH at 2, resp 0x8001_0000 -> 0xFFFF8001.
//  T4 LW at 0x1002 -> no req_valid, wb_valid + misaligned=1 one cycle after issue.
//  T5 LW in WAIT, clear_en pulse, resp 2 cycles later ->
//     no wb_valid, ex_busy drops cycle after resp; next uop accepted.
//  T6 rs1=0xFFFFFFFC imm=8 SW -> req_addr=0x00000004 (wrap);
//     reset asserted in REQ -> req_valid=0 next cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-entry load/store execution unit with a valid/ready dmem port
// Latches one issued memory uop, runs one request, aligns load data and presents it for writeback.
package mem_access_pkg;
  localparam int MEM_XLEN = 32;

  typedef struct packed {
    logic                valid;
    logic                mem_type;      // 1 = store, 0 = load
    logic [1:0]          mem_size;      // 0 byte, 1 half, 2/3 word
    logic                mem_unsigned;
    logic [4:0]          rd;
    logic [MEM_XLEN-1:0] imm;           // already sign-extended to full width
  } micro_op_t;
endpackage

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int XLEN       = MEM_XLEN,
  parameter int STRB_WIDTH = XLEN / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_en,
  input  micro_op_t             uop_in,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  output logic                  ex_busy,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_we,
  output logic [XLEN-1:0]       req_addr,
  output logic [STRB_WIDTH-1:0] req_wstrb,
  output logic [XLEN-1:0]       req_wdata,
  input  logic                  resp_valid,
  input  logic [XLEN-1:0]       resp_rdata,
  output logic                  wb_valid,
  output micro_op_t             uop_out,
  output logic [XLEN-1:0]       rd_data,
  output logic                  misaligned
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, WB} state_t;

  state_t                state;
  logic [1:0]            ea_lo;
  logic [XLEN-1:0]       ea;
  logic                  ea_misaligned;
  logic [STRB_WIDTH-1:0] store_strb;
  logic [XLEN-1:0]       store_data;
  logic [XLEN-1:0]       load_shifted;
  logic [XLEN-1:0]       load_result;

  assign ea = rs1_data + uop_in.imm;

  always_comb begin
    ea_misaligned = 1'b0;
    store_strb    = '0;
    case (uop_in.mem_size)
      2'd0: store_strb = STRB_WIDTH'(4'b0001) << ea[1:0];
      2'd1: begin
        ea_misaligned = ea[0];
        store_strb    = STRB_WIDTH'(4'b0011) << ea[1:0];
      end
      default: begin
        ea_misaligned = |ea[1:0];
        store_strb    = '1;
      end
    endcase
    store_data = rs2_data << {ea[1:0], 3'b000};
  end

  // Load alignment uses the byte offset captured at issue, not the live operands.
  always_comb begin
    load_shifted = resp_rdata >> {ea_lo, 3'b000};
    case (uop_out.mem_size)
      2'd0: load_result = uop_out.mem_unsigned ?
                          {{(XLEN-8){1'b0}}, load_shifted[7:0]} :
                          {{(XLEN-8){load_shifted[7]}}, load_shifted[7:0]};
      2'd1: load_result = uop_out.mem_unsigned ?
                          {{(XLEN-16){1'b0}}, load_shifted[15:0]} :
                          {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
      default: load_result = load_shifted;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ea_lo      <= '0;
      ex_busy    <= 1'b0;
      req_valid  <= 1'b0;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wstrb  <= '0;
      req_wdata  <= '0;
      wb_valid   <= 1'b0;
      uop_out    <= '0;
      rd_data    <= '0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (uop_in.valid && !clear_en) begin
            uop_out <= uop_in;
            ea_lo   <= ea[1:0];
            rd_data <= '0;
            ex_busy <= 1'b1;
            if (ea_misaligned) begin
              state      <= WB;
              wb_valid   <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              state     <= REQ;
              req_valid <= 1'b1;
              req_we    <= uop_in.mem_type;
              req_addr  <= {ea[XLEN-1:2], 2'b00};
              req_wstrb <= uop_in.mem_type ? store_strb : '0;
              req_wdata <= uop_in.mem_type ? store_data : '0;
            end
          end
        end
        REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            if (req_we) begin
              // A flushed store has still been handed to dmem; only its writeback is dropped.
              if (clear_en) begin
                state   <= IDLE;
                ex_busy <= 1'b0;
              end else begin
                state    <= WB;
                wb_valid <= 1'b1;
              end
            end else begin
              state <= clear_en ? DRAIN : WAIT;
            end
          end else if (clear_en) begin
            state     <= IDLE;
            req_valid <= 1'b0;
            ex_busy   <= 1'b0;
          end
        end
        WAIT: begin
          if (resp_valid) begin
            if (clear_en) begin
              state   <= IDLE;
              ex_busy <= 1'b0;
            end else begin
              state    <= WB;
              rd_data  <= load_result;
              wb_valid <= 1'b1;
            end
          end else if (clear_en) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (resp_valid) begin
            state   <= IDLE;
            ex_busy <= 1'b0;
          end
        end
        WB: begin
          state      <= IDLE;
          wb_valid   <= 1'b0;
          misaligned <= 1'b0;
          ex_busy    <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          ex_busy   <= 1'b0;
          req_valid <= 1'b0;
          wb_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
// Stimulus process predicts requests/writebacks; a negedge monitor pops and compares them.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clock = 1'b0;
  logic        reset, clear_en;
  micro_op_t   uop_in;
  logic [31:0] rs1_data, rs2_data;
  logic        ex_busy, req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        wb_valid, misaligned;
  micro_op_t   uop_out;
  logic [31:0] rd_data;

  mem_access_unit dut (
    .clock(clock), .reset(reset), .clear_en(clear_en), .uop_in(uop_in),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_busy(ex_busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .wb_valid(wb_valid),
    .uop_out(uop_out), .rd_data(rd_data), .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } exp_req_t;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic [4:0]  tag;
    int          issue_cyc;
    int          lat;        // 0 = latency not checked
  } exp_wb_t;

  exp_req_t req_q[$];
  exp_wb_t  wb_q[$];
  exp_req_t er;
  exp_wb_t  ew;
  int checks = 0, failures = 0, cyc = 0, wb_count = 0;
  logic reset_seen;

  always @(posedge clock) begin
    cyc        <= cyc + 1;
    reset_seen <= reset;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: byte-lane arithmetic straight from the memory rules.
  function automatic logic [31:0] model_load(input logic [31:0] w, input int off, input int nb, input bit uns);
    longint v, span;
    if (nb == 4) return w;
    span = longint'(1) << (8 * nb);
    v = (longint'(w) >> (8 * off)) % span;
    if (!uns && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_strb(input int off, input int nb);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + nb) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] rs2, input int off);
    logic [63:0] t;
    t = {32'b0, rs2} << (8 * off);
    return t[31:0];
  endfunction

  task automatic push_req(input bit st, input int sz, input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2);
    logic [31:0] ea;
    exp_req_t r;
    ea = rs1 + imm;
    r.we    = st;
    r.addr  = ea - (ea % 4);
    r.strb  = st ? model_strb(int'(ea % 4), 1 << sz) : 4'b0;
    r.wdata = st ? model_wdata(rs2, int'(ea % 4)) : 32'b0;
    req_q.push_back(r);
  endtask

  // Monitor: compares every request handshake and writeback against the queues.
  always @(negedge clock) begin
    if (reset_seen === 1'b1) begin
      checks++;
      if (req_valid || wb_valid || ex_busy) begin
        failures++;
        $display("FAIL reset_outputs req_valid=%0b wb_valid=%0b ex_busy=%0b required all 0", req_valid, wb_valid, ex_busy);
      end
    end else if (reset_seen === 1'b0) begin
      if (req_valid && req_ready) begin
        checks++;
        if (req_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_req actual addr=%h we=%0b required no request", req_addr, req_we);
        end else begin
          er = req_q.pop_front();
          if (req_we !== er.we || req_addr !== er.addr || req_wstrb !== er.strb || (er.we && req_wdata !== er.wdata)) begin
            failures++;
            $display("FAIL req_fields actual we=%0b addr=%h strb=%b wdata=%h required we=%0b addr=%h strb=%b wdata=%h",
                     req_we, req_addr, req_wstrb, req_wdata, er.we, er.addr, er.strb, er.wdata);
          end
        end
      end
      if (wb_valid) begin
        wb_count++;
        checks++;
        if (wb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_wb actual rd_data=%h misaligned=%0b required no writeback", rd_data, misaligned);
        end else begin
          ew = wb_q.pop_front();
          if (rd_data !== ew.rd || misaligned !== ew.mis || uop_out.rd !== ew.tag) begin
            failures++;
            $display("FAIL wb_fields actual rd_data=%h mis=%0b tag=%0d required rd_data=%h mis=%0b tag=%0d",
                     rd_data, misaligned, uop_out.rd, ew.rd, ew.mis, ew.tag);
          end
          if (ew.lat != 0) check("wb_latency", 32'(cyc - ew.issue_cyc), 32'(ew.lat));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (ex_busy !== 1'b0 && n < 30) begin
      tick();
      n++;
    end
    if (n == 30) check("idle_timeout", 32'(ex_busy), 32'd0);
  endtask

  task automatic drive_uop(input bit st, input int sz, input bit uns, input logic [4:0] rd,
                           input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2);
    uop_in              = '0;
    uop_in.valid        = 1'b1;
    uop_in.mem_type     = st;
    uop_in.mem_size     = 2'(sz);
    uop_in.mem_unsigned = uns;
    uop_in.rd           = rd;
    uop_in.imm          = imm;
    rs1_data            = rs1;
    rs2_data            = rs2;
  endtask

  task automatic run_uop(input bit st, input int sz, input bit uns, input logic [31:0] rs1,
                         input logic [31:0] imm, input logic [31:0] rs2, input logic [31:0] word,
                         input int stall, input int rdly, input int lat,
                         output int req_cycles, output bit busy_ok);
    logic [31:0] ea;
    int off, nb, start_wb, st_left, rc;
    bit mis, hs, responded, done;
    exp_wb_t w;
    wait_idle();
    ea = rs1 + imm;
    nb = 1 << sz;
    off = int'(ea % 4);
    mis = (off % nb) != 0;
    w.tag = 5'($urandom_range(0, 31));
    w.rd = (mis || st) ? 32'b0 : model_load(word, off, nb, uns);
    w.mis = mis;
    w.issue_cyc = cyc;
    w.lat = lat;
    if (!mis) push_req(st, sz, rs1, imm, rs2);
    wb_q.push_back(w);
    drive_uop(st, sz, uns, w.tag, rs1, imm, rs2);
    start_wb = wb_count;
    st_left = stall;
    rc = 0;
    hs = 0; responded = 0; done = 0;
    req_cycles = 0;
    busy_ok = 1;
    for (int k = 0; k < 40 && !done; k++) begin
      tick();
      uop_in.valid = 1'b0;
      resp_valid = 1'b0;
      req_ready = 1'b0;
      resp_rdata = $urandom;
      if (wb_count != start_wb) begin
        done = 1;
      end else begin
        if (ex_busy !== 1'b1) busy_ok = 0;
        if (hs && !st && !responded) begin
          if (rc == 0) begin
            resp_valid = 1'b1;
            resp_rdata = word;
            responded = 1;
          end else rc--;
        end
        if (req_valid && !hs) begin
          req_cycles++;
          if (st_left == 0) begin
            req_ready = 1'b1;
            hs = 1;
            rc = rdly;
          end else st_left--;
        end
      end
    end
    if (!done) check("wb_timeout", 32'(wb_count - start_wb), 32'd1);
  endtask

  initial begin
    int rcyc;
    bit bok;
    logic [31:0] r1, im, tgt, x;
    int sz;
    bit st;

    reset = 1; clear_en = 0; uop_in = '0; rs1_data = 0; rs2_data = 0;
    req_ready = 0; resp_valid = 0; resp_rdata = 0;
    repeat (3) tick();
    reset = 0;
    check("reset_req_valid", 32'(req_valid), 32'd0);
    check("reset_wb_valid", 32'(wb_valid), 32'd0);
    check("reset_ex_busy", 32'(ex_busy), 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_uop_out", uop_out.imm, 32'd0);
    tick();

    // T1 LW 0x1000+4, immediate ready, response next cycle: writeback at cycle 3
    run_uop(0, 2, 0, 32'h1000, 32'd4, 32'h0, 32'hDEADBEEF, 0, 0, 3, rcyc, bok);
    check("t1_busy", 32'(bok), 32'd1);
    // T2 SB at 0x2003 with three stalled cycles
    run_uop(1, 0, 0, 32'h2003, 32'd0, 32'hAB, 32'h0, 3, 0, 0, rcyc, bok);
    check("t2_req_cycles", 32'(rcyc), 32'd4);
    check("t2_busy", 32'(bok), 32'd1);
    // T3 sub-word loads at byte offset 2
    run_uop(0, 0, 0, 32'h3000, 32'd2, 32'h0, 32'h0080_0000, 0, 1, 0, rcyc, bok);
    run_uop(0, 0, 1, 32'h3000, 32'd2, 32'h0, 32'h0080_0000, 1, 0, 0, rcyc, bok);
    run_uop(0, 1, 0, 32'h3000, 32'd2, 32'h0, 32'h8001_0000, 0, 2, 0, rcyc, bok);
    // T4 misaligned word load: no request, writeback one cycle after issue
    run_uop(0, 2, 0, 32'h1002, 32'd0, 32'h0, 32'h0, 0, 0, 1, rcyc, bok);
    check("t4_no_req", 32'(rcyc), 32'd0);
    // Minimum store latency and address wrap
    run_uop(1, 2, 0, 32'hFFFF_FFFC, 32'd8, 32'h1234_5678, 32'h0, 0, 0, 2, rcyc, bok);

    // T5 flush while waiting for load data
    wait_idle();
    drive_uop(0, 2, 0, 5'd7, 32'h4000, 32'h0, 32'h0);
    push_req(0, 2, 32'h4000, 32'h0, 32'h0);
    tick(); uop_in.valid = 0; req_ready = 1;
    tick(); req_ready = 0; clear_en = 1;
    tick(); clear_en = 0;
    check("t5_drain_busy", 32'(ex_busy), 32'd1);
    tick(); resp_valid = 1; resp_rdata = 32'h5555_AAAA;
    check("t5_busy_at_resp", 32'(ex_busy), 32'd1);
    tick(); resp_valid = 0;
    check("t5_release", 32'(ex_busy), 32'd0);
    run_uop(0, 1, 1, 32'h4000, 32'd2, 32'h0, 32'hFEDC_BA98, 0, 0, 3, rcyc, bok);

    // Flush in REQ before the handshake drops the request
    wait_idle();
    drive_uop(1, 2, 0, 5'd3, 32'h5000, 32'h0, 32'h1);
    tick(); uop_in.valid = 0; clear_en = 1;
    tick(); clear_en = 0;
    check("req_flush_valid", 32'(req_valid), 32'd0);
    check("req_flush_busy", 32'(ex_busy), 32'd0);
    // Store handshake coincident with flush: committed, no writeback
    drive_uop(1, 1, 0, 5'd4, 32'h5000, 32'h2, 32'hBEEF);
    push_req(1, 1, 32'h5000, 32'h2, 32'hBEEF);
    tick(); uop_in.valid = 0; req_ready = 1; clear_en = 1;
    tick(); req_ready = 0; clear_en = 0;
    check("store_flush_idle", 32'(ex_busy), 32'd0);
    // Load handshake coincident with flush: drains one response
    drive_uop(0, 2, 0, 5'd5, 32'h6000, 32'h0, 32'h0);
    push_req(0, 2, 32'h6000, 32'h0, 32'h0);
    tick(); uop_in.valid = 0; req_ready = 1; clear_en = 1;
    tick(); req_ready = 0; clear_en = 0;
    check("load_flush_drain", 32'(ex_busy), 32'd1);
    resp_valid = 1;
    tick(); resp_valid = 0;
    check("load_flush_release", 32'(ex_busy), 32'd0);
    // uop ignored while clear_en is high
    drive_uop(0, 2, 0, 5'd6, 32'h7000, 32'h0, 32'h0);
    clear_en = 1;
    tick(); uop_in.valid = 0; clear_en = 0;
    check("clear_blocks_issue", 32'(ex_busy), 32'd0);

    // T6 reset while a store request is pending
    drive_uop(1, 2, 0, 5'd8, 32'h8000, 32'h0, 32'h1);
    tick(); uop_in.valid = 0;
    check("t6_in_req", 32'(req_valid), 32'd1);
    reset = 1;
    tick(); reset = 0;
    check("t6_req_dropped", 32'(req_valid), 32'd0);
    tick();

    for (int n = 0; n < 200; n++) begin
      st = 1'($urandom_range(0, 1));
      sz = $urandom_range(0, 2);
      x = $urandom;
      im = {{20{x[11]}}, x[11:0]};
      r1 = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        tgt = ($urandom & 32'hFFFF_FFFC) | ((32'($urandom_range(0, 3)) >> sz) << sz);
        r1 = tgt - im;
      end
      run_uop(st, sz, 1'($urandom_range(0, 1)), r1, im, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 2), 0, rcyc, bok);
      check("rand_busy", 32'(bok), 32'd1);
    end

    repeat (3) tick();
    check("req_q_empty", 32'(req_q.size()), 32'd0);
    check("wb_q_empty", 32'(wb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
